lif_spike_aer_encoder: RTL and testbench

- Consumes the N-bit parallel spike vector from a LIF neuron array.
- Serializes it into a stream of address events (AER): one neuron index per beat, over a valid/ready handshake.
- Buffers bursts in an internal FIFO. Arbitrates simultaneous spikes round-robin. Counts spikes lost to collisions.
- Sits between the neuron array's spike_out bus and the downstream spike router or host interface.

---
 rtl/lif_spike_aer_encoder_if.sv | 28 ++
 rtl/lif_spike_aer_encoder.sv | 158 +++++++++++++++
 tb/tb_lif_spike_aer_encoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lif_spike_aer_encoder_if.sv
// rtl/lif_spike_aer_encoder_if.sv - address-event stream handshake between encoder and consumer
//
// Purpose: carries one address event per beat over a valid/ready handshake.
// Optional feature macro: AER_TIMESTAMP_EN (adds aer_ts alongside aer_addr).
// Signals:
//   aer_valid  master -> slave  event available
//   aer_addr   master -> slave  neuron index of the head event
//   aer_ready  slave -> master  consumer accepts the event this cycle
//   aer_ts     master -> slave  grant-cycle timestamp (AER_TIMESTAMP_EN only)
interface lif_spike_aer_encoder_if #(
    parameter int ADDR_W = 2
`ifdef AER_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
);
    logic              aer_valid;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ready;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]   aer_ts;

    modport master (output aer_valid, output aer_addr, output aer_ts, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, input aer_ts, output aer_ready);
`else
    modport master (output aer_valid, output aer_addr, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, output aer_ready);
`endif
endinterface

// File: rtl/lif_spike_aer_encoder.sv
// rtl/lif_spike_aer_encoder.sv - serializes a LIF spike vector into a round-robin AER event stream
//
// Purpose: latches spikes into a pending register, grants one pending neuron
// per cycle in round-robin order, buffers granted indices in a show-ahead FIFO
// and counts spikes lost when a neuron fires again before its previous spike
// was granted.
// Optional feature macro: AER_TIMESTAMP_EN (free-running timestamp stored per event).
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   spike_in    N-bit spike vector, one-cycle pulse per spike
//   aer         event stream (master side): aer_valid, aer_addr, aer_ready [, aer_ts]
//   drop_count  saturating count of dropped spikes
//   overflow    sticky, set on the first dropped spike
module lif_spike_aer_encoder #(
    parameter int N      = 4,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
`ifdef AER_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            spike_in,
    lif_spike_aer_encoder_if.master aer,
    output logic [DROP_W-1:0]       drop_count,
    output logic                    overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int POP_W = $clog2(N + 1);
    localparam int SUM_W = ((DROP_W > POP_W) ? DROP_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

    logic [N-1:0]      r_pend;
    logic [ADDR_W-1:0] r_rr_last;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DROP_W-1:0] r_drop_count;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];

    logic [N-1:0]      w_grant;
    logic [ADDR_W-1:0] w_grant_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [N-1:0]      w_drop_vec;
    logic [POP_W-1:0]  w_pop_cnt;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [DROP_W-1:0] w_drop_next;

    // Round-robin search starts one past the last winner and wraps modulo N.
    // Grant is withheld while the FIFO is full, even if a pop happens this cycle,
    // so the full-FIFO decision never depends on the downstream ready.
    always_comb begin
        int idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        w_grant     = '0;
        w_grant_idx = '0;
        if ((r_pend != '0) && (r_count < DEPTH_C)) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(r_rr_last) + k) % N;
                if (!found && r_pend[idx]) begin
                    found        = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_grant_idx  = ADDR_W'(idx);
                end
            end
        end
    end

    assign w_push  = (w_grant != '0);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && aer.aer_ready;

    // A re-fire on the bit granted this cycle is kept (bit stays set), not dropped.
    assign w_drop_vec = spike_in & r_pend & ~w_grant;

    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_pop_cnt = w_pop_cnt + POP_W'(w_drop_vec[i]);
        end
    end

    assign w_drop_sum  = SUM_W'(r_drop_count) + SUM_W'(w_pop_cnt);
    assign w_drop_next = (w_drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : w_drop_sum[DROP_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= '0;
            r_rr_last    <= ADDR_W'(N - 1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | spike_in;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                r_rr_last <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop_vec != '0) begin
                r_drop_count <= w_drop_next;
                r_overflow   <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while r_count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_grant_idx;
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_ts;
        end
    end

    assign aer.aer_ts = w_valid ? r_mem_ts[r_rd_ptr] : '0;
`endif

    assign aer.aer_valid = w_valid;
    assign aer.aer_addr  = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign drop_count    = r_drop_count;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_lif_spike_aer_encoder.sv
// tb/tb_lif_spike_aer_encoder.sv - directed self-checking bench for lif_spike_aer_encoder
module tb_lif_spike_aer_encoder;
    logic       clk;
    logic       reset;
    logic [3:0] spike_in;
    logic [3:0] spike_sat;
    logic [7:0] drop_count;
    logic       overflow;
    logic [1:0] drop_sat;
    logic       overflow_sat;
    int         checks;
    int         errors;

    lif_spike_aer_encoder_if #(.ADDR_W(2)) aer_if ();
    lif_spike_aer_encoder_if #(.ADDR_W(2)) sat_if ();

    lif_spike_aer_encoder #(.N(4), .ADDR_W(2), .DEPTH(8), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .aer(aer_if),
        .drop_count(drop_count), .overflow(overflow)
    );

    lif_spike_aer_encoder #(.N(4), .ADDR_W(2), .DEPTH(8), .DROP_W(2)) dut_sat (
        .clk(clk), .reset(reset), .spike_in(spike_sat), .aer(sat_if),
        .drop_count(drop_sat), .overflow(overflow_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        spike_in = 4'b0000;
        spike_sat = 4'b0000;
        aer_if.aer_ready = 1'b1;
        sat_if.aer_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spike_in = 4'b1111;
        aer_if.aer_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d: got %0b exp 0", c, aer_if.aer_valid); end
            checks++;
            if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop cyc %0d: got %0d exp 0", c, drop_count); end
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf cyc %0d: got %0b exp 0", c, overflow); end
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== (c == 2)) begin errors++; $display("FAIL reset_first_valid cyc %0d: got %0b exp %0b", c, aer_if.aer_valid, (c == 2)); end
            if (c == 2) begin
                checks++;
                if (aer_if.aer_addr !== 2'd0) begin errors++; $display("FAIL reset_first_addr: got %0d exp 0", aer_if.aer_addr); end
            end
            @(posedge clk); #1 spike_in = 4'b0000;
        end
    endtask

    task automatic test_single_spike();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            spike_in = (c == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== (c == 2)) begin errors++; $display("FAIL single_valid cyc %0d: got %0b exp %0b", c, aer_if.aer_valid, (c == 2)); end
            checks++;
            if (aer_if.aer_addr !== ((c == 2) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL single_addr cyc %0d: got %0d exp %0d", c, aer_if.aer_addr, (c == 2) ? 2 : 0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        logic       exp_v [12] = '{0,0,1,1,1,0,0,1,1,1,1,0};
        logic [1:0] exp_a [12] = '{0,0,0,1,3,0,0,0,1,2,3,0};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            spike_in = (c == 0) ? 4'b1011 : ((c == 5) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== exp_v[c]) begin errors++; $display("FAIL rr_valid cyc %0d: got %0b exp %0b", c, aer_if.aer_valid, exp_v[c]); end
            checks++;
            if (aer_if.aer_addr !== exp_a[c]) begin errors++; $display("FAIL rr_addr cyc %0d: got %0d exp %0d", c, aer_if.aer_addr, exp_a[c]); end
            @(posedge clk); #1;
        end
        checks++;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL rr_no_drop: got %0d exp 0", drop_count); end
    endtask

    task automatic test_collision();
        logic       exp_v [8] = '{0,0,1,1,1,1,1,0};
        logic [1:0] exp_a [8] = '{0,0,0,1,2,3,0,0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            spike_in = (c < 2) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== exp_v[c]) begin errors++; $display("FAIL coll_valid cyc %0d: got %0b exp %0b", c, aer_if.aer_valid, exp_v[c]); end
            checks++;
            if (aer_if.aer_addr !== exp_a[c]) begin errors++; $display("FAIL coll_addr cyc %0d: got %0d exp %0d", c, aer_if.aer_addr, exp_a[c]); end
            checks++;
            if (drop_count !== ((c < 2) ? 8'd0 : 8'd3)) begin errors++; $display("FAIL coll_drop cyc %0d: got %0d exp %0d", c, drop_count, (c < 2) ? 0 : 3); end
            checks++;
            if (overflow !== (c >= 2)) begin errors++; $display("FAIL coll_ovf cyc %0d: got %0b exp %0b", c, overflow, (c >= 2)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 27; c++) begin
            spike_in = ((c % 4 == 0) && (c <= 12)) ? 4'b1111 : 4'b0000;
            aer_if.aer_ready = (c >= 14);
            @(negedge clk);
            if (c < 14) begin
                checks++;
                if (aer_if.aer_valid !== (c >= 2)) begin errors++; $display("FAIL bp_stall_valid cyc %0d: got %0b exp %0b", c, aer_if.aer_valid, (c >= 2)); end
                checks++;
                if (aer_if.aer_addr !== 2'd0) begin errors++; $display("FAIL bp_stall_addr cyc %0d: got %0d exp 0", c, aer_if.aer_addr); end
                checks++;
                if (drop_count !== ((c == 13) ? 8'd4 : 8'd0)) begin errors++; $display("FAIL bp_drop cyc %0d: got %0d exp %0d", c, drop_count, (c == 13) ? 4 : 0); end
            end else if (c < 26) begin
                checks++;
                if (aer_if.aer_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid cyc %0d: got %0b exp 1", c, aer_if.aer_valid); end
                checks++;
                if (aer_if.aer_addr !== 2'((c - 14) % 4)) begin errors++; $display("FAIL bp_drain_addr cyc %0d: got %0d exp %0d", c, aer_if.aer_addr, (c - 14) % 4); end
            end else begin
                checks++;
                if (aer_if.aer_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid: got %0b exp 0", aer_if.aer_valid); end
                checks++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %0b exp 1", overflow); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        aer_if.aer_ready = 1'b0;
        spike_in = 4'b1111;
        @(posedge clk); #1 spike_in = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (aer_if.aer_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid: got %0b exp 1", aer_if.aer_valid); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        aer_if.aer_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (aer_if.aer_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid cyc %0d: got %0b exp 0", c, aer_if.aer_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_d [8] = '{0,0,1,2,3,3,3,3};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            spike_sat = (c <= 5) ? 4'b0011 : 4'b0000;
            @(negedge clk);
            checks++;
            if (drop_sat !== exp_d[c]) begin errors++; $display("FAIL sat_drop cyc %0d: got %0d exp %0d", c, drop_sat, exp_d[c]); end
            checks++;
            if (overflow_sat !== (c >= 2)) begin errors++; $display("FAIL sat_ovf cyc %0d: got %0b exp %0b", c, overflow_sat, (c >= 2)); end
            if (c == 2) begin
                checks++;
                if (sat_if.aer_valid !== 1'b1 || sat_if.aer_addr !== 2'd0) begin errors++; $display("FAIL sat_event: got v=%0b a=%0d exp v=1 a=0", sat_if.aer_valid, sat_if.aer_addr); end
            end
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (drop_sat !== 2'd0) begin errors++; $display("FAIL sat_reset_drop: got %0d exp 0", drop_sat); end
        checks++;
        if (overflow_sat !== 1'b0) begin errors++; $display("FAIL sat_reset_ovf: got %0b exp 0", overflow_sat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        spike_in = 4'b0000;
        spike_sat = 4'b0000;
        aer_if.aer_ready = 1'b1;
        sat_if.aer_ready = 1'b1;
        test_reset();
        test_single_spike();
        test_round_robin();
        test_collision();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
